// File: rtl/regfile_write_arbiter.sv
// Two-source writeback arbiter for a single-write-port register file.
// Each source owns a one-entry holding register. Held entries are written
// oldest first, and two entries accepted in the same cycle are ordered by
// a round-robin flag. Writes to r0 are acknowledged but never held.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [ADDR_WIDTH-1:0]    a_addr,
    input  logic [DATA_WIDTH-1:0]    a_data,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [ADDR_WIDTH-1:0]    b_addr,
    input  logic [DATA_WIDTH-1:0]    b_data,
    output logic                     rf_available,
    output logic                     rf_write_en,
    output logic [ADDR_WIDTH-1:0]    rf_write_addr,
    output logic [DATA_WIDTH-1:0]    rf_write_data,
    output logic [2**ADDR_WIDTH-1:0] pending_mask
);

    localparam int NREG = 2**ADDR_WIDTH;

    logic                  held_a_q, held_a_d;
    logic                  held_b_q, held_b_d;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
    logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
    logic [DATA_WIDTH-1:0] data_a_q, data_a_d;
    logic [DATA_WIDTH-1:0] data_b_q, data_b_d;
    // older_a is meaningful only when same_age is clear.
    logic                  older_a_q, older_a_d;
    logic                  same_age_q, same_age_d;
    logic                  rr_b_q, rr_b_d;
    logic                  avail_q;

    logic grant_a, grant_b;
    logic acc_a, acc_b;

    // Pick one held entry: oldest first, round-robin between equal-age entries.
    always_comb begin
        grant_a = avail_q & held_a_q &
                  (~held_b_q | (same_age_q ? ~rr_b_q : older_a_q));
        grant_b = avail_q & held_b_q & ~grant_a;
    end

    // Handshakes; a slot can refill in the same cycle its entry is written.
    always_comb begin
        a_ready = ~reset & ~flush & (~held_a_q | grant_a);
        b_ready = ~reset & ~flush & (~held_b_q | grant_b);
        acc_a   = a_valid & a_ready & (a_addr != '0);
        acc_b   = b_valid & b_ready & (b_addr != '0);
    end

    // Next state for holding registers, relative age and tie-break flag.
    always_comb begin
        held_a_d   = flush ? 1'b0 : ((held_a_q & ~grant_a) | acc_a);
        held_b_d   = flush ? 1'b0 : ((held_b_q & ~grant_b) | acc_b);
        addr_a_d   = acc_a ? a_addr : addr_a_q;
        data_a_d   = acc_a ? a_data : data_a_q;
        addr_b_d   = acc_b ? b_addr : addr_b_q;
        data_b_d   = acc_b ? b_data : data_b_q;
        older_a_d  = older_a_q;
        same_age_d = same_age_q;
        if (flush) begin
            older_a_d  = 1'b0;
            same_age_d = 1'b0;
        end else if (acc_a && acc_b) begin
            same_age_d = 1'b1;
        end else if (acc_a) begin
            // Whatever B holds (or later holds) is older than this A entry.
            older_a_d  = 1'b0;
            same_age_d = 1'b0;
        end else if (acc_b) begin
            older_a_d  = 1'b1;
            same_age_d = 1'b0;
        end
        // A tie is consumed when one member of an equal-age pair is written.
        rr_b_d = rr_b_q ^ (held_a_q & held_b_q & same_age_q & avail_q);
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            held_a_q   <= 1'b0;
            held_b_q   <= 1'b0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            data_a_q   <= '0;
            data_b_q   <= '0;
            older_a_q  <= 1'b0;
            same_age_q <= 1'b0;
            rr_b_q     <= 1'b0;
            avail_q    <= 1'b0;
        end else begin
            held_a_q   <= held_a_d;
            held_b_q   <= held_b_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            older_a_q  <= older_a_d;
            same_age_q <= same_age_d;
            rr_b_q     <= rr_b_d;
            avail_q    <= 1'b1;
        end
    end

    // Register file write port, zeroed when nothing is granted.
    always_comb begin
        rf_available  = avail_q;
        rf_write_en   = grant_a | grant_b;
        rf_write_addr = '0;
        rf_write_data = '0;
        if (grant_a) begin
            rf_write_addr = addr_a_q;
            rf_write_data = data_a_q;
        end else if (grant_b) begin
            rf_write_addr = addr_b_q;
            rf_write_data = data_b_q;
        end
    end

    // Pending-write mask; r0 is never held so bit 0 is tied low.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_mask
        if (gi == 0) begin : g_zero
            assign pending_mask[gi] = 1'b0;
        end else begin : g_reg
            assign pending_mask[gi] =
                (held_a_q && (addr_a_q == ADDR_WIDTH'(gi))) ||
                (held_b_q && (addr_b_q == ADDR_WIDTH'(gi)));
        end
    end

endmodule
